lcd_hd44780_ctrl: RTL and testbench

//  Parametrised HD44780 character-LCD controller; successor to the fixed 2x16, 8-bit, static-text LCD driver.

---
 rtl/lcd_pkg.sv | 44 ++++
 rtl/lcd_bus_tx.sv | 129 ++++++++++++
 rtl/lcd_hd44780_ctrl.sv | 212 +++++++++++++++++++++
 tb/tb_lcd_hd44780_ctrl.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared constants for the HD44780 controller: command bytes, function-set
// bits, DDRAM line base addresses, the top FSM state encoding and the
// request payload passed from the sequencer to the bus transmitter.
package lcd_pkg;

    localparam logic [7:0] CMD_CLEAR     = 8'h01;
    localparam logic [7:0] CMD_HOME      = 8'h02;
    localparam logic [7:0] CMD_ENTRY_INC = 8'h06;
    localparam logic [7:0] CMD_DISP_ON   = 8'h0C;
    localparam logic [7:0] CMD_FS_BASE   = 8'h20;
    localparam logic [7:0] FS_8BIT       = 8'h10;
    localparam logic [7:0] FS_2LINE      = 8'h08;
    localparam logic [7:0] CMD_SET_DDRAM = 8'h80;
    localparam logic [7:0] CHAR_BLANK    = 8'h20;

    // 4-bit wake-up nibbles, carried in the high nibble of the payload byte
    localparam logic [7:0] NIB_WAKE      = 8'h30;
    localparam logic [7:0] NIB_4BIT      = 8'h20;

    // Top FSM state encoding
    localparam logic [2:0] ST_POWERUP    = 3'd0;
    localparam logic [2:0] ST_INIT       = 3'd1;
    localparam logic [2:0] ST_DRAW_ADDR  = 3'd2;
    localparam logic [2:0] ST_DRAW_CHAR  = 3'd3;
    localparam logic [2:0] ST_IDLE       = 3'd4;

    // One transfer request: byte, register select, send high nibble only
    typedef struct packed {
        logic [7:0] data;
        logic       rs;
        logic       nibble_only;
    } tx_req_t;

    // DDRAM address of column 0 for each display line
    function automatic logic [7:0] line_base(input logic [1:0] line);
        case (line)
            2'd0:    line_base = 8'h00;
            2'd1:    line_base = 8'h40;
            2'd2:    line_base = 8'h14;
            default: line_base = 8'h54;
        endcase
    endfunction

endpackage

// File: rtl/lcd_bus_tx.sv
// Byte transmitter for the HD44780 bus. Accepts one request (held until ack),
// drives rs/data one cycle ahead of E, holds E high PULSE_CYCLES, then waits
// CMD_WAIT_CYCLES (CLEAR_WAIT_CYCLES after the final strobe of a clear/home
// command). In 4-bit mode each byte goes out as two nibbles, high first.
// Ports: clk, reset (async, active high), req/payload in, ack out (1-cycle
// pulse after the post-strobe wait), lcd_en/lcd_rs/lcd_data pin outputs.
module lcd_bus_tx
    import lcd_pkg::*;
#(
    parameter bit          BUS_4BIT          = 1'b0,
    parameter int unsigned PULSE_CYCLES      = 25,
    parameter int unsigned CMD_WAIT_CYCLES   = 2500,
    parameter int unsigned CLEAR_WAIT_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req,
    input  tx_req_t    payload,
    output logic       ack,
    output logic       lcd_en,
    output logic       lcd_rs,
    output logic [7:0] lcd_data
);

    localparam int unsigned MAX_A   = (PULSE_CYCLES > CMD_WAIT_CYCLES) ? PULSE_CYCLES : CMD_WAIT_CYCLES;
    localparam int unsigned MAX_CNT = (MAX_A > CLEAR_WAIT_CYCLES) ? MAX_A : CLEAR_WAIT_CYCLES;
    localparam int unsigned CNT_W   = $clog2(MAX_CNT + 1);

    localparam logic [2:0] TX_IDLE  = 3'd0;
    localparam logic [2:0] TX_SETUP = 3'd1;
    localparam logic [2:0] TX_PULSE = 3'd2;
    localparam logic [2:0] TX_WAIT  = 3'd3;
    localparam logic [2:0] TX_ACK   = 3'd4;

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             lo_pend_q, lo_pend_d;
    logic [3:0]       lo_nib_q, lo_nib_d;
    logic             long_q, long_d;
    logic             en_d, rs_d, ack_d;
    logic [7:0]       data_d;

    // State and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= TX_IDLE;
            cnt_q     <= '0;
            lo_pend_q <= 1'b0;
            lo_nib_q  <= 4'h0;
            long_q    <= 1'b0;
            lcd_en    <= 1'b0;
            lcd_rs    <= 1'b0;
            lcd_data  <= 8'h00;
            ack       <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            lo_pend_q <= lo_pend_d;
            lo_nib_q  <= lo_nib_d;
            long_q    <= long_d;
            lcd_en    <= en_d;
            lcd_rs    <= rs_d;
            lcd_data  <= data_d;
            ack       <= ack_d;
        end
    end

    // Strobe sequencing
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        lo_pend_d = lo_pend_q;
        lo_nib_d  = lo_nib_q;
        long_d    = long_q;
        en_d      = lcd_en;
        rs_d      = lcd_rs;
        data_d    = lcd_data;
        ack_d     = 1'b0;

        case (state_q)
            TX_IDLE: begin
                if (req) begin
                    rs_d      = payload.rs;
                    long_d    = !payload.rs && ((payload.data == CMD_CLEAR) || (payload.data == CMD_HOME));
                    lo_nib_d  = payload.data[3:0];
                    lo_pend_d = BUS_4BIT && !payload.nibble_only;
                    data_d    = BUS_4BIT ? {payload.data[7:4], 4'h0} : payload.data;
                    state_d   = TX_SETUP;
                end
            end
            TX_SETUP: begin
                en_d    = 1'b1;
                cnt_d   = CNT_W'(PULSE_CYCLES - 1);
                state_d = TX_PULSE;
            end
            TX_PULSE: begin
                if (cnt_q == '0) begin
                    en_d    = 1'b0;
                    state_d = TX_WAIT;
                    // Long wait only after the last strobe of a clear/home
                    cnt_d   = (long_q && !lo_pend_q) ? CNT_W'(CLEAR_WAIT_CYCLES - 1)
                                                     : CNT_W'(CMD_WAIT_CYCLES - 1);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            TX_WAIT: begin
                if (cnt_q == '0) begin
                    if (lo_pend_q) begin
                        data_d    = {lo_nib_q, 4'h0};
                        lo_pend_d = 1'b0;
                        state_d   = TX_SETUP;
                    end else begin
                        ack_d   = 1'b1;
                        state_d = TX_ACK;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            TX_ACK: begin
                // req is still high this cycle; it is ignored until IDLE
                state_d = TX_IDLE;
            end
            default: state_d = TX_IDLE;
        endcase
    end

endmodule

// File: rtl/lcd_hd44780_ctrl.sv
// HD44780 character-LCD controller: power-up wait, init sequence (8- or
// 4-bit), then redraws a runtime-writable character buffer on request.
// Ports: clk, reset (async, active high); wr_en_i/wr_addr_i/wr_data_i buffer
// write; refresh_i redraw request; busy_o, done_o status; lcd_rs, lcd_rw,
// lcd_en, lcd_data LCD pins.
module lcd_hd44780_ctrl
    import lcd_pkg::*;
#(
    parameter bit          BUS_4BIT          = 1'b0,
    parameter int unsigned NUM_LINES         = 2,
    parameter int unsigned CHARS_PER_LINE    = 16,
    parameter int unsigned PULSE_CYCLES      = 25,
    parameter int unsigned CMD_WAIT_CYCLES   = 2500,
    parameter int unsigned CLEAR_WAIT_CYCLES = 100000,
    parameter int unsigned POWERUP_CYCLES    = 2000000,
    localparam int unsigned DEPTH            = NUM_LINES * CHARS_PER_LINE,
    localparam int unsigned AW               = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_en_i,
    input  logic [AW-1:0] wr_addr_i,
    input  logic [7:0]    wr_data_i,
    input  logic          refresh_i,
    output logic          busy_o,
    output logic          done_o,
    output logic          lcd_rs,
    output logic          lcd_rw,
    output logic          lcd_en,
    output logic [7:0]    lcd_data
);

    localparam int unsigned PW         = $clog2(POWERUP_CYCLES + 1);
    localparam int unsigned INIT_STEPS = BUS_4BIT ? 8 : 4;
    localparam logic [7:0]  FS_CMD     = CMD_FS_BASE | (BUS_4BIT ? 8'h00 : FS_8BIT)
                                       | ((NUM_LINES > 1) ? FS_2LINE : 8'h00);

    logic [2:0]    state_q, state_d;
    logic [2:0]    step_q, step_d;
    logic [1:0]    line_q, line_d;
    logic [5:0]    col_q, col_d;
    logic [PW-1:0] pwr_q, pwr_d;
    logic          req_q, req_d;
    tx_req_t       pay_q, pay_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          pending_q, pending_d;
    logic          tx_ack;
    tx_req_t       init_pay;
    logic [AW-1:0] rd_idx;
    logic [7:0]    buf_q [DEPTH];

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign lcd_rw = 1'b0;
    assign rd_idx = AW'(32'(line_q) * CHARS_PER_LINE + 32'(col_q));

    // Character buffer; out-of-range writes are dropped
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) buf_q[i] <= CHAR_BLANK;
        end else if (wr_en_i && (32'(wr_addr_i) < DEPTH)) begin
            buf_q[wr_addr_i] <= wr_data_i;
        end
    end

    // Init command for the current step; 4-bit mode prepends wake-up nibbles
    always_comb begin
        init_pay = '{data: FS_CMD, rs: 1'b0, nibble_only: 1'b0};
        if (BUS_4BIT && (step_q < 3'd4)) begin
            init_pay.data        = (step_q == 3'd3) ? NIB_4BIT : NIB_WAKE;
            init_pay.nibble_only = 1'b1;
        end else begin
            case (2'(step_q))
                2'd0:    init_pay.data = FS_CMD;
                2'd1:    init_pay.data = CMD_DISP_ON;
                2'd2:    init_pay.data = CMD_ENTRY_INC;
                default: init_pay.data = CMD_CLEAR;
            endcase
        end
    end

    // State registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_POWERUP;
            step_q    <= 3'd0;
            line_q    <= 2'd0;
            col_q     <= 6'd0;
            pwr_q     <= PW'(POWERUP_CYCLES - 1);
            req_q     <= 1'b0;
            pay_q     <= '0;
            busy_q    <= 1'b1;
            done_q    <= 1'b0;
            pending_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            step_q    <= step_d;
            line_q    <= line_d;
            col_q     <= col_d;
            pwr_q     <= pwr_d;
            req_q     <= req_d;
            pay_q     <= pay_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            pending_q <= pending_d;
        end
    end

    // Sequencer: one request per byte, held until the transmitter acks
    always_comb begin
        state_d   = state_q;
        step_d    = step_q;
        line_d    = line_q;
        col_d     = col_q;
        pwr_d     = pwr_q;
        req_d     = req_q;
        pay_d     = pay_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        // Requests while busy collapse into a single pending redraw
        pending_d = pending_q | (refresh_i && (state_q != ST_IDLE));

        case (state_q)
            ST_POWERUP: begin
                if (pwr_q == '0) begin
                    state_d = ST_INIT;
                    step_d  = 3'd0;
                end else begin
                    pwr_d = pwr_q - PW'(1);
                end
            end
            ST_INIT: begin
                if (!req_q) begin
                    req_d = 1'b1;
                    pay_d = init_pay;
                end else if (tx_ack) begin
                    req_d = 1'b0;
                    if (32'(step_q) == INIT_STEPS - 1) begin
                        state_d = ST_DRAW_ADDR;
                        line_d  = 2'd0;
                    end else begin
                        step_d = step_q + 3'd1;
                    end
                end
            end
            ST_DRAW_ADDR: begin
                if (!req_q) begin
                    req_d = 1'b1;
                    pay_d = '{data: CMD_SET_DDRAM | line_base(line_q), rs: 1'b0, nibble_only: 1'b0};
                end else if (tx_ack) begin
                    req_d   = 1'b0;
                    col_d   = 6'd0;
                    state_d = ST_DRAW_CHAR;
                end
            end
            ST_DRAW_CHAR: begin
                if (!req_q) begin
                    // Buffer sampled here: a same-cycle write is not yet visible
                    req_d = 1'b1;
                    pay_d = '{data: buf_q[rd_idx], rs: 1'b1, nibble_only: 1'b0};
                end else if (tx_ack) begin
                    req_d = 1'b0;
                    if (32'(col_q) == CHARS_PER_LINE - 1) begin
                        col_d = 6'd0;
                        if (32'(line_q) == NUM_LINES - 1) begin
                            done_d = 1'b1;
                            line_d = 2'd0;
                            if (pending_d) begin
                                pending_d = 1'b0;
                                state_d   = ST_DRAW_ADDR;
                            end else begin
                                busy_d  = 1'b0;
                                state_d = ST_IDLE;
                            end
                        end else begin
                            line_d  = line_q + 2'd1;
                            state_d = ST_DRAW_ADDR;
                        end
                    end else begin
                        col_d = col_q + 6'd1;
                    end
                end
            end
            ST_IDLE: begin
                if (refresh_i) begin
                    busy_d  = 1'b1;
                    line_d  = 2'd0;
                    state_d = ST_DRAW_ADDR;
                end
            end
            default: state_d = ST_POWERUP;
        endcase
    end

    lcd_bus_tx #(
        .BUS_4BIT          (BUS_4BIT),
        .PULSE_CYCLES      (PULSE_CYCLES),
        .CMD_WAIT_CYCLES   (CMD_WAIT_CYCLES),
        .CLEAR_WAIT_CYCLES (CLEAR_WAIT_CYCLES)
    ) u_tx (
        .clk      (clk),
        .reset    (reset),
        .req      (req_q),
        .payload  (pay_q),
        .ack      (tx_ack),
        .lcd_en   (lcd_en),
        .lcd_rs   (lcd_rs),
        .lcd_data (lcd_data)
    );

endmodule

// File: tb/tb_lcd_hd44780_ctrl.sv
// Directed bench: A = 8-bit 2x16, B = 4-bit 2x16, C = 8-bit 4x20.
module tb_lcd_hd44780_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // DUT A: 8-bit, 2x16
    logic       rst_a = 1'b1, wr_en_a = 1'b0, refresh_a = 1'b0;
    logic [4:0] wr_addr_a = '0;
    logic [7:0] wr_data_a = '0;
    logic       busy_a, done_a, rs_a, rw_a, en_a;
    logic [7:0] data_a;

    // DUT B: 4-bit, 2x16
    logic       rst_b = 1'b1, wr_en_b = 1'b0, refresh_b = 1'b0;
    logic [4:0] wr_addr_b = '0;
    logic [7:0] wr_data_b = '0;
    logic       busy_b, done_b, rs_b, rw_b, en_b;
    logic [7:0] data_b;

    // DUT C: 8-bit, 4x20
    logic       rst_c = 1'b1, wr_en_c = 1'b0, refresh_c = 1'b0;
    logic [6:0] wr_addr_c = '0;
    logic [7:0] wr_data_c = '0;
    logic       busy_c, done_c, rs_c, rw_c, en_c;
    logic [7:0] data_c;

    lcd_hd44780_ctrl #(.BUS_4BIT(1'b0), .NUM_LINES(2), .CHARS_PER_LINE(16), .PULSE_CYCLES(2),
                       .CMD_WAIT_CYCLES(4), .CLEAR_WAIT_CYCLES(8), .POWERUP_CYCLES(10))
    dut_a (.clk(clk), .reset(rst_a), .wr_en_i(wr_en_a), .wr_addr_i(wr_addr_a), .wr_data_i(wr_data_a),
           .refresh_i(refresh_a), .busy_o(busy_a), .done_o(done_a), .lcd_rs(rs_a), .lcd_rw(rw_a),
           .lcd_en(en_a), .lcd_data(data_a));

    lcd_hd44780_ctrl #(.BUS_4BIT(1'b1), .NUM_LINES(2), .CHARS_PER_LINE(16), .PULSE_CYCLES(2),
                       .CMD_WAIT_CYCLES(4), .CLEAR_WAIT_CYCLES(8), .POWERUP_CYCLES(10))
    dut_b (.clk(clk), .reset(rst_b), .wr_en_i(wr_en_b), .wr_addr_i(wr_addr_b), .wr_data_i(wr_data_b),
           .refresh_i(refresh_b), .busy_o(busy_b), .done_o(done_b), .lcd_rs(rs_b), .lcd_rw(rw_b),
           .lcd_en(en_b), .lcd_data(data_b));

    lcd_hd44780_ctrl #(.BUS_4BIT(1'b0), .NUM_LINES(4), .CHARS_PER_LINE(20), .PULSE_CYCLES(2),
                       .CMD_WAIT_CYCLES(4), .CLEAR_WAIT_CYCLES(8), .POWERUP_CYCLES(10))
    dut_c (.clk(clk), .reset(rst_c), .wr_en_i(wr_en_c), .wr_addr_i(wr_addr_c), .wr_data_i(wr_data_c),
           .refresh_i(refresh_c), .busy_o(busy_c), .done_o(done_c), .lcd_rs(rs_c), .lcd_rw(rw_c),
           .lcd_en(en_c), .lcd_data(data_c));

    int n_cmp = 0, n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Strobe monitors, sampled on the falling clock edge
    logic [8:0] q_a[$];
    logic       busy_at_done_a[$];
    int         done_cnt_a = 0, width_bad_a = 0, stab_bad_a = 0, hi_cnt_a = 0;
    int         gap_a = 0, min_clr_gap_a = 9999, busy_gap_a = 0;
    logic       en_prev_a = 1'b0, clr_seen_a = 1'b0;
    logic [8:0] prev_bus_a = '0;

    always @(negedge clk) begin
        if (en_a && !en_prev_a) begin
            q_a.push_back({rs_a, data_a});
            if (clr_seen_a && gap_a < min_clr_gap_a) min_clr_gap_a = gap_a;
            clr_seen_a = 1'b0;
        end
        if (en_a && ({rs_a, data_a} != prev_bus_a)) stab_bad_a++;
        if (en_a) hi_cnt_a++;
        if (!en_a && en_prev_a) begin
            if (hi_cnt_a != 2) width_bad_a++;
            hi_cnt_a = 0;
            if ({rs_a, data_a} == 9'h001) begin
                clr_seen_a = 1'b1;
                gap_a      = 0;
            end
        end
        if (!en_a) gap_a++;
        if (done_cnt_a == 3 && !busy_a && !done_a) busy_gap_a++;
        if (done_a) begin
            done_cnt_a++;
            busy_at_done_a.push_back(busy_a);
        end
        en_prev_a  = en_a;
        prev_bus_a = {rs_a, data_a};
    end

    logic [4:0] q_b[$];
    int         done_cnt_b = 0, lowbad_b = 0;
    logic       en_prev_b = 1'b0;

    always @(negedge clk) begin
        if (en_b && !en_prev_b) q_b.push_back({rs_b, data_b[7:4]});
        if (data_b[3:0] != 4'h0) lowbad_b++;
        if (done_b) done_cnt_b++;
        en_prev_b = en_b;
    end

    logic [8:0] q_c[$];
    int         done_cnt_c = 0;
    logic       en_prev_c = 1'b0;

    always @(negedge clk) begin
        if (en_c && !en_prev_c) q_c.push_back({rs_c, data_c});
        if (done_c) done_cnt_c++;
        en_prev_c = en_c;
    end

    function automatic int done_of(input int sel);
        case (sel)
            0:       done_of = done_cnt_a;
            1:       done_of = done_cnt_b;
            default: done_of = done_cnt_c;
        endcase
    endfunction

    task automatic wait_done(input int sel, input int target, input int budget);
        int cnt;
        cnt = 0;
        while (done_of(sel) < target && cnt < budget) begin
            @(negedge clk);
            cnt++;
        end
        if (done_of(sel) < target)
            chk($sformatf("timeout dut%0d done", sel), 32'(done_of(sel)), 32'(target));
    endtask

    // i-th strobe of a draw: address command per line, then cpl chars
    function automatic logic [8:0] exp_draw(input int i, input int cpl, input int mod_idx,
                                            input logic [7:0] mod_val);
        int ln, k;
        logic [7:0] base;
        ln = i / (cpl + 1);
        k  = i % (cpl + 1);
        case (ln)
            0:       base = 8'h00;
            1:       base = 8'h40;
            2:       base = 8'h14;
            default: base = 8'h54;
        endcase
        if (k == 0) return {1'b0, 8'h80 | base};
        return {1'b1, ((ln * cpl + k - 1) == mod_idx) ? mod_val : 8'h20};
    endfunction

    task automatic pulse_refresh_a();
        @(negedge clk) refresh_a = 1'b1;
        @(negedge clk) refresh_a = 1'b0;
    endtask

    logic [8:0] init8 [4];
    logic [4:0] eb[$];
    int         guard;

    initial begin
        init8 = '{9'h038, 9'h00C, 9'h006, 9'h001};
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst en", 32'(en_a), 32'd0);
        chk("rst rs", 32'(rs_a), 32'd0);
        chk("rst rw", 32'(rw_a), 32'd0);
        chk("rst data", 32'(data_a), 32'd0);
        chk("rst busy", 32'(busy_a), 32'd1);
        chk("rst done", 32'(done_a), 32'd0);

        // 1: power-up, init, automatic first draw
        rst_a = 1'b0;
        wait_done(0, 1, 3000);
        chk("t1 strobes", 32'(q_a.size()), 32'd38);
        for (int i = 0; i < 38 && i < q_a.size(); i++)
            chk($sformatf("t1 strobe %0d", i), 32'(q_a[i]),
                32'((i < 4) ? init8[i] : exp_draw(i - 4, 16, -1, 8'h00)));
        if (busy_at_done_a.size() > 0) chk("t1 busy at done", 32'(busy_at_done_a[0]), 32'd0);
        repeat (20) @(negedge clk);
        chk("t1 done count", 32'(done_cnt_a), 32'd1);
        chk("t1 busy idle", 32'(busy_a), 32'd0);

        // 5: strobe timing over everything so far
        chk("t5 pulse width", 32'(width_bad_a), 32'd0);
        chk("t5 bus stable", 32'(stab_bad_a), 32'd0);
        chk("t5 clear gap>=8", 32'(min_clr_gap_a >= 8), 32'd1);

        // 2: buffer write then refresh
        q_a.delete();
        @(negedge clk);
        wr_en_a = 1'b1; wr_addr_a = 5'd17; wr_data_a = 8'h41;
        @(negedge clk) wr_en_a = 1'b0;
        pulse_refresh_a();
        wait_done(0, 2, 3000);
        chk("t2 strobes", 32'(q_a.size()), 32'd34);
        for (int i = 0; i < 34 && i < q_a.size(); i++)
            chk($sformatf("t2 strobe %0d", i), 32'(q_a[i]), 32'(exp_draw(i, 16, 17, 8'h41)));

        // 4: two refreshes during a draw collapse to one extra draw
        q_a.delete();
        repeat (5) @(negedge clk);
        pulse_refresh_a();
        repeat (40) @(negedge clk);
        pulse_refresh_a();
        repeat (30) @(negedge clk);
        pulse_refresh_a();
        wait_done(0, 4, 6000);
        repeat (60) @(negedge clk);
        chk("t4 done count", 32'(done_cnt_a), 32'd4);
        chk("t4 strobes", 32'(q_a.size()), 32'd68);
        for (int i = 0; i < 68 && i < q_a.size(); i++)
            chk($sformatf("t4 strobe %0d", i), 32'(q_a[i]), 32'(exp_draw(i % 34, 16, 17, 8'h41)));
        if (busy_at_done_a.size() >= 4) begin
            chk("t4 busy at 1st done", 32'(busy_at_done_a[2]), 32'd1);
            chk("t4 busy at 2nd done", 32'(busy_at_done_a[3]), 32'd0);
        end
        chk("t4 busy gap", 32'(busy_gap_a), 32'd0);
        chk("t5 pulse width all", 32'(width_bad_a), 32'd0);
        chk("t5 bus stable all", 32'(stab_bad_a), 32'd0);

        // 3: 4-bit nibble sequence
        eb = '{5'h03, 5'h03, 5'h03, 5'h02, 5'h02, 5'h08, 5'h00, 5'h0C,
               5'h00, 5'h06, 5'h00, 5'h01, 5'h08, 5'h00};
        for (int i = 0; i < 16; i++) begin eb.push_back(5'h12); eb.push_back(5'h10); end
        eb.push_back(5'h0C); eb.push_back(5'h00);
        for (int i = 0; i < 16; i++) begin eb.push_back(5'h12); eb.push_back(5'h10); end
        rst_b = 1'b0;
        wait_done(1, 1, 6000);
        chk("t3 nibbles", 32'(q_b.size()), 32'(eb.size()));
        for (int i = 0; i < eb.size() && i < q_b.size(); i++)
            chk($sformatf("t3 nibble %0d", i), 32'(q_b[i]), 32'(eb[i]));
        chk("t3 low nibble zero", 32'(lowbad_b), 32'd0);
        chk("t3 busy idle", 32'(busy_b), 32'd0);

        // 6: 4x20 line addresses, then reset mid-draw
        rst_c = 1'b0;
        wait_done(2, 1, 6000);
        chk("t6 strobes", 32'(q_c.size()), 32'd88);
        if (q_c.size() >= 88) begin
            chk("t6 fs", 32'(q_c[0]), 32'h038);
            chk("t6 line0", 32'(q_c[4]), 32'h080);
            chk("t6 line1", 32'(q_c[25]), 32'h0C0);
            chk("t6 line2", 32'(q_c[46]), 32'h094);
            chk("t6 line3", 32'(q_c[67]), 32'h0D4);
        end
        @(negedge clk);
        wr_en_c = 1'b1; wr_addr_c = 7'd21; wr_data_c = 8'h5A;
        @(negedge clk) wr_en_c = 1'b0;
        refresh_c = 1'b1;
        @(negedge clk) refresh_c = 1'b0;
        guard = 0;
        while (q_c.size() < 98 && guard < 3000) begin @(negedge clk); guard++; end
        guard = 0;
        while (!en_c && guard < 100) begin @(negedge clk); guard++; end
        chk("t6 mid-strobe reached", 32'(en_c), 32'd1);
        rst_c = 1'b1;
        #1;
        chk("t6 reset en", 32'(en_c), 32'd0);
        chk("t6 reset data", 32'(data_c), 32'd0);
        chk("t6 reset busy", 32'(busy_c), 32'd1);
        q_c.delete();
        @(negedge clk) rst_c = 1'b0;
        wait_done(2, 2, 6000);
        chk("t6 restart strobes", 32'(q_c.size()), 32'd88);
        if (q_c.size() >= 88) begin
            chk("t6 restart fs", 32'(q_c[0]), 32'h038);
            chk("t6 restart clear", 32'(q_c[3]), 32'h001);
            chk("t6 blank buffer", 32'(q_c[27]), 32'h120);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
